gfsk_frame_scheduler: RTL and testbench



---
 rtl/gfsk_frame_scheduler.sv | 158 +++++++++++++++
 tb/tb_gfsk_frame_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfsk_frame_scheduler.sv
// GFSK burst sequencer: serializes preamble, sync word, buffered payload and a zero tail
// into the Gaussian filter at one symbol per SPS clocks.
module gfsk_frame_scheduler #(
  parameter int unsigned SPS            = 16,
  parameter int unsigned PREAMBLE_BYTES = 4,
  parameter logic [15:0] SYNC_WORD      = 16'hD391,
  parameter int unsigned TAIL_BITS      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       bit_out,
  output logic       bit_strobe,
  output logic       tx_busy,
  output logic       done,
  output logic       underrun
);
  localparam int unsigned   SW        = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [SW-1:0] SYM_LAST  = SW'(SPS - 1);
  localparam logic [15:0]   PRE_LAST  = 16'(PREAMBLE_BYTES * 8 - 1);
  localparam logic [15:0]   TAIL_LAST = 16'(TAIL_BITS - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, TAIL} state_t;

  state_t        state;
  logic [SW-1:0] sym_cnt;
  logic [15:0]   phase_cnt;
  logic [15:0]   shreg;
  logic [7:0]    len_q;
  logic [7:0]    fetched;
  logic [7:0]    buf_data;
  logic          buf_full;

  logic       sym_end;
  logic       pay_last;
  logic       load_now;
  logic       hs;
  logic [7:0] load_byte;

  assign tx_busy    = (state != IDLE);
  assign bit_strobe = tx_busy && (sym_cnt == '0);
  assign sym_end    = tx_busy && (sym_cnt == SYM_LAST);
  assign pay_last   = (phase_cnt[10:3] == len_q - 8'd1);
  assign load_now   = sym_end &&
                      (((state == SYNC) && (phase_cnt == 16'd15) && (len_q != 8'd0)) ||
                       ((state == PAYLOAD) && (phase_cnt[2:0] == 3'd7) && !pay_last));
  assign load_byte  = buf_full ? buf_data : 8'h00;

  // An empty-buffer load consumes a slot by itself, so a handshake in that same cycle
  // must still fit inside len for fetched never to overshoot.
  assign s_ready = !buf_full && ((state == SYNC) || (state == PAYLOAD)) &&
                   (({1'b0, fetched} + {8'd0, load_now}) < {1'b0, len_q});
  assign hs      = s_valid && s_ready;

  // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sym_cnt   <= '0;
      phase_cnt <= '0;
      shreg     <= '0;
      len_q     <= '0;
      fetched   <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      bit_out   <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;
      sym_cnt  <= (sym_end || !tx_busy) ? '0 : sym_cnt + 1'b1;
      fetched  <= fetched + 8'(hs) + 8'(load_now && !buf_full);

      if (hs) buf_data <= s_data;
      if (load_now)  buf_full <= hs;
      else if (hs)   buf_full <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= PREAMBLE;
            len_q     <= len;
            fetched   <= '0;
            buf_full  <= 1'b0;
            phase_cnt <= '0;
            bit_out   <= 1'b1;
            shreg     <= 16'h5555;
          end
        end
        PREAMBLE: begin
          if (sym_end) begin
            if (phase_cnt == PRE_LAST) begin
              state     <= SYNC;
              phase_cnt <= '0;
              bit_out   <= SYNC_WORD[15];
              shreg     <= {SYNC_WORD[14:0], 1'b0};
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
              bit_out   <= shreg[15];
              shreg     <= {shreg[14:0], shreg[15]};
            end
          end
        end
        SYNC: begin
          if (sym_end) begin
            if (phase_cnt == 16'd15) begin
              state     <= (len_q == 8'd0) ? TAIL : PAYLOAD;
              phase_cnt <= '0;
              bit_out   <= 1'b0;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
              bit_out   <= shreg[15];
              shreg     <= {shreg[14:0], shreg[15]};
            end
          end
        end
        PAYLOAD: begin
          if (sym_end) begin
            if (phase_cnt[2:0] == 3'd7 && pay_last) begin
              state     <= TAIL;
              phase_cnt <= '0;
              bit_out   <= 1'b0;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
              bit_out   <= shreg[15];
              shreg     <= {shreg[14:0], shreg[15]};
            end
          end
        end
        TAIL: begin
          if (sym_end) begin
            bit_out <= 1'b0;
            if (phase_cnt == TAIL_LAST) begin
              state     <= IDLE;
              phase_cnt <= '0;
              done      <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Byte boundary: the shift register takes the buffered byte, or zeros on underrun.
      if (load_now) begin
        bit_out  <= load_byte[7];
        shreg    <= {load_byte[6:0], 9'd0};
        underrun <= !buf_full;
      end
    end
  end
endmodule

// File: tb/tb_gfsk_frame_scheduler.sv
// Scoreboard bench: stimulus pushes the expected symbol stream and burst-end events,
// a negedge monitor pops and compares on every bit_strobe and done pulse.
module tb_gfsk_frame_scheduler;
  localparam int PRE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] s_data = 8'd0;

  logic start_a, start_b;
  logic s_ready_a, bit_out_a, bit_strobe_a, tx_busy_a, done_a, underrun_a;
  logic s_ready_b, bit_out_b, bit_strobe_b, tx_busy_b, done_b, underrun_b;
  logic s_ready, bit_out, bit_strobe, tx_busy, done, underrun;

  assign start_a = start && !sel;
  assign start_b = start && sel;

  gfsk_frame_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .len(len), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready_a), .bit_out(bit_out_a), .bit_strobe(bit_strobe_a), .tx_busy(tx_busy_a),
    .done(done_a), .underrun(underrun_a)
  );

  // Fast instance: SPS=2 with a 5-bit tail, so a 1-byte burst is 61 symbols.
  gfsk_frame_scheduler #(.SPS(2), .TAIL_BITS(5)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_b), .len(len), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready_b), .bit_out(bit_out_b), .bit_strobe(bit_strobe_b), .tx_busy(tx_busy_b),
    .done(done_b), .underrun(underrun_b)
  );

  assign s_ready    = sel ? s_ready_b    : s_ready_a;
  assign bit_out    = sel ? bit_out_b    : bit_out_a;
  assign bit_strobe = sel ? bit_strobe_b : bit_strobe_a;
  assign tx_busy    = sel ? tx_busy_b    : tx_busy_a;
  assign done       = sel ? done_b       : done_a;
  assign underrun   = sel ? underrun_b   : underrun_a;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic b; logic ur; logic first; int t; } sym_t;
  typedef struct { int t; int hs; } done_t;
  sym_t  exp_q[$];
  done_t done_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pay[256];
  bit         stv[256];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sps_cur();
    return sel ? 2 : 16;
  endfunction

  function automatic int tail_cur();
    return sel ? 5 : 4;
  endfunction

  function automatic int burst_end(input int t, input int n);
    return t + 1 + (8 * PRE + 16 + 8 * n + tail_cur()) * sps_cur();
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference burst: alternating preamble, sync MSB-first, payload (zeros for starved slots), zero tail.
  task automatic push_burst(input int t, input int n);
    logic [15:0] sw;
    int hs;
    sw = 16'hD391;
    hs = 0;
    for (int i = 0; i < 8 * PRE; i++) exp_q.push_back('{(i % 2) == 0, 1'b0, i == 0, t + 1});
    for (int i = 0; i < 16; i++) exp_q.push_back('{sw[15 - i], 1'b0, 1'b0, 0});
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++)
        exp_q.push_back('{stv[k] ? 1'b0 : pay[k][7 - j], stv[k] && j == 0, 1'b0, 0});
      if (!stv[k]) hs++;
    end
    for (int i = 0; i < tail_cur(); i++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 0});
    done_q.push_back('{burst_end(t, n), hs});
  endtask

  task automatic issue_start(input int n, input bit hold, output int t);
    start = 1'b1;
    len   = 8'(n);
    t     = cyc;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Each present byte is offered at a random point after the previous byte boundary,
  // always at least two cycles before the boundary where it is needed.
  task automatic drive_payload(input int t, input int n);
    int sps, c0, win;
    bit ok;
    sps = sps_cur();
    for (int k = 0; k < n; k++) begin
      c0  = (k == 0) ? t + 1 + 8 * PRE * sps : t + 1 + (8 * PRE + 16 + 8 * (k - 1)) * sps + 1;
      win = (k == 0) ? 16 * sps - 4 : 8 * sps - 4;
      if (!stv[k]) begin
        wait_until(c0 + int'($urandom_range(0, win)));
        s_data  = pay[k];
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int w = 0; w < 8 * sps && !ok; w++) begin
          if (s_ready) ok = 1'b1;
          @(posedge clk);
          #1;
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        check("hs_seen", ok, 1);
      end
    end
  endtask

  task automatic run_burst(input int n);
    int t;
    issue_start(n, 1'b0, t);
    push_burst(t, n);
    drive_payload(t, n);
    wait_until(burst_end(t, n) + 2);
  endtask

  task automatic check_quiet();
    check("q_busy", tx_busy, 0);
    check("q_bit", bit_out, 0);
    check("q_strobe", bit_strobe, 0);
    check("q_done", done, 0);
    check("q_underrun", underrun, 0);
    check("q_ready", s_ready, 0);
  endtask

  logic  last_bit = 1'b0;
  int    last_t = 0;
  int    hs_cnt = 0;
  sym_t  e;
  done_t d;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_cnt = 0;
    end else begin
      if (s_valid && s_ready) hs_cnt++;
      check("ready_idle", s_ready && !tx_busy, 0);
      if (bit_strobe) begin
        if (exp_q.size() == 0) check("extra_strobe", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("bit", bit_out, e.b);
          check("underrun", underrun, e.ur);
          if (e.first) check("first_strobe_t", cyc, e.t);
          else         check("strobe_gap", cyc - last_t, sps_cur());
        end
        last_t   = cyc;
        last_bit = bit_out;
      end else begin
        check("underrun_off", underrun, 0);
        check("bit_hold", bit_out, tx_busy ? last_bit : 1'b0);
      end
      if (done) begin
        check("done_idle", tx_busy || bit_strobe || bit_out, 0);
        if (done_q.size() == 0) check("extra_done", 1, 0);
        else begin
          d = done_q.pop_front();
          check("done_t", cyc, d.t);
          check("hs_count", hs_cnt, d.hs);
        end
        hs_cnt = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, t3, n;

    repeat (3) @(posedge clk);
    #1;
    check_quiet();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_quiet();

    // Default burst: 0x5A, 0xC3 offered ahead of need.
    pay[0] = 8'h5A; pay[1] = 8'hC3; stv[0] = 1'b0; stv[1] = 1'b0;
    run_burst(2);

    // Zero-length burst with s_valid held high: no handshake may happen.
    s_valid = 1'b1;
    s_data  = 8'hEE;
    run_burst(0);
    s_valid = 1'b0;

    // Underrun on the middle byte; that slot still counts, so only two handshakes occur.
    pay[0] = 8'h96; pay[1] = 8'h3C; pay[2] = 8'hE1;
    stv[0] = 1'b0;  stv[1] = 1'b1;  stv[2] = 1'b0;
    run_burst(3);

    // Mid-burst start with a different len is ignored.
    pay[0] = 8'h81; pay[1] = 8'h7E; stv[0] = 1'b0; stv[1] = 1'b0;
    issue_start(2, 1'b0, t);
    push_burst(t, 2);
    wait_until(t + 100);
    start = 1'b1;
    len   = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive_payload(t, 2);
    wait_until(burst_end(t, 2) + 2);

    // start held high: the next burst begins in the done cycle, with len sampled there.
    pay[0] = 8'h4B; stv[0] = 1'b0;
    issue_start(1, 1'b1, t2);
    len = 8'd0;
    push_burst(t2, 1);
    t3 = burst_end(t2, 1);
    push_burst(t3, 0);
    drive_payload(t2, 1);
    wait_until(t3 + 1);
    start = 1'b0;
    wait_until(burst_end(t3, 0) + 2);

    // Asynchronous reset in the middle of the payload, then a clean burst.
    for (int k = 0; k < 4; k++) begin pay[k] = 8'($urandom); stv[k] = 1'b0; end
    issue_start(4, 1'b0, t);
    push_burst(t, 4);
    drive_payload(t, 2);
    wait_until(t + 1 + (8 * PRE + 16 + 8) * 16 + 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet();
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_quiet();
    run_burst(4);

    // Randomized bursts with occasional starved slots.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(0, 5));
      for (int k = 0; k < n; k++) begin
        pay[k] = 8'($urandom);
        stv[k] = ($urandom_range(0, 3) == 0);
      end
      run_burst(n);
    end

    // SPS=2, len=1 on the fast instance.
    sel = 1'b1;
    @(posedge clk);
    #1;
    pay[0] = 8'($urandom); stv[0] = 1'b0;
    run_burst(1);
    sel = 1'b0;

    check("exp_left", exp_q.size(), 0);
    check("done_left", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
